// File: rtl/xadc_seq_pkg.sv
// Shared types and DRP constants for the XADC channel sequencer.
// Addresses and config values target single-channel event mode.
package xadc_seq_pkg;

  typedef enum logic [3:0] {
    IDLE,
    CFG_WR,
    CFG_WAIT,
    CONV,
    EOC_WAIT,
    RD,
    RD_WAIT,
    STORE,
    DONE
  } seq_state_t;

  localparam logic [6:0]  CFG0_ADDR     = 7'h40;
  localparam logic [6:0]  VAUX_RES_BASE = 7'h10;
  localparam logic [4:0]  VAUX_CH_BASE  = 5'h10;
  localparam logic [15:0] CFG0_BASE     = 16'h0200;

endpackage

// File: rtl/xadc_channel_sequencer_if.sv
// DRP / conversion-control bundle between the sequencer (master) and xadc_wiz_0 (slave).
interface xadc_channel_sequencer_if;
  logic [6:0]  ADC_Address;
  logic        Data_En;
  logic        Data_We;
  logic [15:0] Data_Out;
  logic        ADC_SC;
  logic        ADC_Busy;
  logic        ADC_EOC;
  logic        Data_Rdy;
  logic [15:0] ADC_Data_in;

  modport master (
    output ADC_Address, Data_En, Data_We, Data_Out, ADC_SC,
    input  ADC_Busy, ADC_EOC, Data_Rdy, ADC_Data_in
  );

  modport slave (
    input  ADC_Address, Data_En, Data_We, Data_Out, ADC_SC,
    output ADC_Busy, ADC_EOC, Data_Rdy, ADC_Data_in
  );
endinterface

// File: rtl/xadc_prio_next.sv
// Finds the next enabled channel: lowest set bit when starting a frame,
// otherwise the lowest set bit strictly above the current index (no wrap).
module xadc_prio_next (
  input  logic [15:0] mask,
  input  logic [3:0]  cur,
  input  logic        from_start,
  output logic [3:0]  nxt,
  output logic        none
);

  always_comb begin
    nxt  = '0;
    none = 1'b1;
    // Descending scan so the lowest qualifying bit is the last one written.
    for (int i = 15; i >= 0; i--) begin
      if (mask[i] && (from_start || (4'(i) > cur))) begin
        nxt  = 4'(i);
        none = 1'b0;
      end
    end
  end

endmodule

// File: rtl/xadc_channel_sequencer.sv
// Round-robin XADC DRP sequencer: per Start, configures, converts and reads each enabled VAUX channel.
// Optional build macro XSEQ_AVG_EN turns on a 1/4-weight running average per channel.
module xadc_channel_sequencer
  import xadc_seq_pkg::*;
#(
  parameter  int TIMEOUT_CLKS = 4096,
  localparam int TW           = $clog2(TIMEOUT_CLKS + 1)
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      Start,
  input  logic [15:0]               ChanMask,
  xadc_channel_sequencer_if.master  drp,
  input  logic [3:0]                RdIdx,
  output logic [11:0]               RdData,
  output logic                      RdValid,
  output logic                      Frame_Done,
  output logic                      Seq_Busy,
  output logic                      Error
);

  seq_state_t      state_q, state_d;
  logic [15:0]     mask_q;
  logic [3:0]      idx_q;
  logic [11:0]     sample_q;
  logic [TW-1:0]   tmo_q;
  logic            err_q;
  logic [11:0]     result_q [16];
  logic [15:0]     valid_q;
  logic [11:0]     store_val;

  logic [15:0]     prio_mask;
  logic            prio_first, prio_none;
  logic [3:0]      prio_nxt;
  logic            in_wait, wait_evt, timed_out;
  logic            load_start, advance, do_store, capture, set_err;
  logic            unused_status;

  assign unused_status = ^{drp.ADC_Busy, drp.ADC_Data_in[3:0]};

  assign prio_first = (state_q == IDLE);
  assign prio_mask  = prio_first ? ChanMask : mask_q;

  xadc_prio_next u_prio (
    .mask       (prio_mask),
    .cur        (idx_q),
    .from_start (prio_first),
    .nxt        (prio_nxt),
    .none       (prio_none)
  );

  assign in_wait   = (state_q == CFG_WAIT) || (state_q == EOC_WAIT) || (state_q == RD_WAIT);
  assign wait_evt  = (state_q == EOC_WAIT) ? drp.ADC_EOC : drp.Data_Rdy;
  assign timed_out = in_wait && !wait_evt && (tmo_q == TW'(TIMEOUT_CLKS));

  always_comb begin
    state_d    = state_q;
    load_start = 1'b0;
    advance    = 1'b0;
    do_store   = 1'b0;
    capture    = 1'b0;
    set_err    = 1'b0;
    case (state_q)
      IDLE: if (Start) begin
        load_start = 1'b1;
        state_d    = prio_none ? DONE : CFG_WR;
      end
      CFG_WR:   state_d = CFG_WAIT;
      CFG_WAIT: if (drp.Data_Rdy) state_d = CONV;
      CONV:     state_d = EOC_WAIT;
      EOC_WAIT: if (drp.ADC_EOC) state_d = RD;
      RD:       state_d = RD_WAIT;
      RD_WAIT: if (drp.Data_Rdy) begin
        capture = 1'b1;
        state_d = STORE;
      end
      STORE: begin
        do_store = 1'b1;
        advance  = 1'b1;
      end
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    // An abandoned channel leaves its result untouched and moves on.
    if (timed_out) begin
      set_err = 1'b1;
      advance = 1'b1;
    end
    if (advance) state_d = prio_none ? DONE : CFG_WR;
  end

  always_comb begin
    drp.Data_En     = (state_q == CFG_WR) || (state_q == RD);
    drp.Data_We     = (state_q == CFG_WR);
    drp.ADC_SC      = (state_q == CONV);
    drp.ADC_Address = '0;
    drp.Data_Out    = '0;
    if (state_q == CFG_WR) begin
      drp.ADC_Address = CFG0_ADDR;
      drp.Data_Out    = CFG0_BASE | {11'b0, 5'(VAUX_CH_BASE + {1'b0, idx_q})};
    end else if (state_q == RD) begin
      drp.ADC_Address = VAUX_RES_BASE + {3'b0, idx_q};
    end
  end

`ifdef XSEQ_AVG_EN
  function automatic logic [11:0] avg_update(input logic [11:0] acc, input logic [11:0] s);
    return acc - (acc >> 2) + (s >> 2);
  endfunction

  assign store_val = valid_q[idx_q] ? avg_update(result_q[idx_q], sample_q) : sample_q;
`else
  assign store_val = sample_q;
`endif

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      mask_q  <= '0;
      idx_q   <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
      valid_q <= '0;
      for (int i = 0; i < 16; i++) result_q[i] <= '0;
    end else begin
      state_q <= state_d;
      // Counter restarts whenever a wait state is left, so each wait gets a full budget.
      if (in_wait && (state_d == state_q)) tmo_q <= tmo_q + TW'(1);
      else                                 tmo_q <= '0;
      if (load_start) begin
        mask_q <= ChanMask;
        idx_q  <= prio_nxt;
        err_q  <= 1'b0;
      end
      if (advance) idx_q <= prio_nxt;
      if (set_err) err_q <= 1'b1;
      if (do_store) begin
        result_q[idx_q] <= store_val;
        valid_q[idx_q]  <= 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (capture) sample_q <= drp.ADC_Data_in[15:4];
  end

  assign RdData     = result_q[RdIdx];
  assign RdValid    = valid_q[RdIdx];
  assign Frame_Done = (state_q == DONE);
  assign Seq_Busy   = (state_q != IDLE);
  assign Error      = err_q;

endmodule

// File: tb/tb_xadc_channel_sequencer.sv
// Bench for xadc_channel_sequencer: XADC DRP responder, transaction-level frame model, directed frames.
module tb_xadc_channel_sequencer;

  localparam int TO = 4096;
`ifdef XSEQ_AVG_EN
  localparam bit AVG = 1'b1;
`else
  localparam bit AVG = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] chan_mask = '0;
  logic [3:0]  rd_idx = '0;
  logic [11:0] rd_data;
  logic        rd_valid, frame_done, seq_busy, error;

  xadc_channel_sequencer_if drp_if ();

  xadc_channel_sequencer #(.TIMEOUT_CLKS(TO)) dut (
    .Clk        (clk),
    .Reset      (rst_n),
    .Start      (start),
    .ChanMask   (chan_mask),
    .drp        (drp_if),
    .RdIdx      (rd_idx),
    .RdData     (rd_data),
    .RdValid    (rd_valid),
    .Frame_Done (frame_done),
    .Seq_Busy   (seq_busy),
    .Error      (error)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic end_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  endtask

  // ---------------- frame model ----------------
  typedef struct packed {
    logic        we;
    logic [6:0]  addr;
    logic [15:0] di;
  } drp_t;

  drp_t        exp_q[$];
  drp_t        cmp_t;
  logic [15:0] di_log[$];
  logic [6:0]  rd_log[$];
  logic [11:0] res_m [16];
  logic        valid_m [16];
  logic [15:0] data_tbl [16];
  logic        chk_en = 1'b0;
  logic        in_frame = 1'b0;
  logic        exp_err = 1'b0;
  int          exp_sc, sc_cnt, en_cnt, done_cnt;
  int          cyc = 0, sc_cyc = 0, done_cyc = 0;
  int          withhold = -1;
  int          rdy_lat = 1, eoc_lat = 1;

  function automatic logic [11:0] m_avg(input int old, input int s);
    int v;
    v = old - old / 4 + s / 4;
    return 12'(v);
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (chk_en) begin
      check("seq_busy", 32'(seq_busy), 32'(in_frame));
      if (drp_if.Data_En) begin
        en_cnt++;
        if (exp_q.size() == 0) begin
          check("drp_extra_en", 32'(drp_if.Data_En), 32'd0);
        end else begin
          cmp_t = exp_q.pop_front();
          check("drp_we", 32'(drp_if.Data_We), 32'(cmp_t.we));
          check("drp_addr", 32'(drp_if.ADC_Address), 32'(cmp_t.addr));
          if (cmp_t.we) begin
            check("drp_di", 32'(drp_if.Data_Out), 32'(cmp_t.di));
            di_log.push_back(drp_if.Data_Out);
          end else begin
            rd_log.push_back(drp_if.ADC_Address);
          end
        end
      end else begin
        check("we_without_en", 32'(drp_if.Data_We), 32'd0);
      end
      if (drp_if.ADC_SC) begin
        sc_cnt++;
        sc_cyc = cyc;
      end
      if (frame_done) begin
        done_cnt++;
        done_cyc = cyc;
        check("frame_error", 32'(error), 32'(exp_err));
      end
    end
  end

  // ---------------- XADC responder ----------------
  logic        req_en, req_we, req_sc, m_read;
  logic [6:0]  req_addr, m_addr;
  logic [15:0] req_di;
  int          rdy_cnt = 0, eoc_cnt = 0, cur_ch = 0;

  always begin
    @(negedge clk);
    req_en   = drp_if.Data_En;
    req_we   = drp_if.Data_We;
    req_addr = drp_if.ADC_Address;
    req_di   = drp_if.Data_Out;
    req_sc   = drp_if.ADC_SC;
    @(posedge clk);
    #1;
    drp_if.Data_Rdy = 1'b0;
    drp_if.ADC_EOC  = 1'b0;
    if (!rst_n) begin
      rdy_cnt = 0;
      eoc_cnt = 0;
    end else begin
      if (req_en) begin
        rdy_cnt = rdy_lat;
        m_read  = !req_we;
        m_addr  = req_addr;
        if (req_we) cur_ch = int'(req_di[3:0]);
      end
      if (req_sc && cur_ch != withhold) eoc_cnt = eoc_lat;
      if (rdy_cnt > 0) begin
        rdy_cnt--;
        if (rdy_cnt == 0) begin
          drp_if.Data_Rdy    = 1'b1;
          drp_if.ADC_Data_in = m_read ? data_tbl[m_addr[3:0]] : 16'h0000;
        end
      end
      if (eoc_cnt > 0) begin
        eoc_cnt--;
        if (eoc_cnt == 0) drp_if.ADC_EOC = 1'b1;
      end
    end
    drp_if.ADC_Busy = (eoc_cnt > 0);
  end

  // ---------------- stimulus helpers ----------------
  task automatic start_frame(input logic [15:0] m);
    drp_t t;
    exp_q.delete();
    di_log.delete();
    rd_log.delete();
    sc_cnt = 0; en_cnt = 0; done_cnt = 0; exp_sc = 0;
    exp_err = 1'b0;
    for (int n = 0; n < 16; n++) begin
      if (m[n]) begin
        t.we = 1'b1; t.addr = 7'h40; t.di = 16'h0210 + 16'(n);
        exp_q.push_back(t);
        exp_sc++;
        if (n == withhold) exp_err = 1'b1;
        else begin
          t.we = 1'b0; t.addr = 7'(16 + n); t.di = 16'h0000;
          exp_q.push_back(t);
        end
      end
    end
    @(posedge clk); #1;
    chan_mask = m;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    in_frame = 1'b1;
  endtask

  task automatic wait_done(input int budget, input int pulse_at, input logic [15:0] m, output int lat);
    int k;
    for (k = 1; k <= budget; k++) begin
      @(negedge clk);
      if (frame_done) break;
      if (k == pulse_at) begin
        start = 1'b1;
        chan_mask = 16'hFFFF;
      end else if (k == pulse_at + 1) begin
        start = 1'b0;
        chan_mask = m;
      end
    end
    lat = k;
    if (k > budget) begin
      check("frame_done_timeout", 32'(frame_done), 32'd1);
      end_run();
    end
    @(posedge clk); #1;
    in_frame = 1'b0;
  endtask

  task automatic read_chan(input string name, input int i, input logic [11:0] d, input logic v);
    @(posedge clk); #1;
    rd_idx = 4'(i);
    @(negedge clk);
    check({name, "_data"}, 32'(rd_data), 32'(d));
    check({name, "_valid"}, 32'(rd_valid), 32'(v));
  endtask

  task automatic sweep_store();
    for (int i = 0; i < 16; i++)
      read_chan($sformatf("store_ch%0d", i), i, res_m[i], valid_m[i]);
  endtask

  task automatic finish_frame(input logic [15:0] m);
    check("drp_missing", 32'(exp_q.size()), 32'd0);
    check("sc_count", 32'(sc_cnt), 32'(exp_sc));
    check("done_count", 32'(done_cnt), 32'd1);
    for (int n = 0; n < 16; n++) begin
      if (m[n] && n != withhold) begin
        if (AVG && valid_m[n]) res_m[n] = m_avg(int'(res_m[n]), int'(data_tbl[n][15:4]));
        else                   res_m[n] = data_tbl[n][15:4];
        valid_m[n] = 1'b1;
      end
    end
    sweep_store();
  endtask

  // ---------------- directed sequence ----------------
  int lat;

  initial begin
    drp_if.ADC_Busy    = 1'b0;
    drp_if.ADC_EOC     = 1'b0;
    drp_if.Data_Rdy    = 1'b0;
    drp_if.ADC_Data_in = 16'h0000;
    for (int i = 0; i < 16; i++) begin
      data_tbl[i] = 16'h0000;
      res_m[i]    = 12'h000;
      valid_m[i]  = 1'b0;
    end

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_seq_busy", 32'(seq_busy), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_data_en", 32'(drp_if.Data_En), 32'd0);
    check("rst_adc_sc", 32'(drp_if.ADC_SC), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk_en = 1'b1;
    sweep_store();

    // single channel 6
    data_tbl[6] = 16'hABC0;
    start_frame(16'h0040);
    wait_done(100, 0, 16'h0040, lat);
    finish_frame(16'h0040);
    check("t1_cfg_di", 32'(di_log[0]), 32'h0216);
    check("t1_rd_addr", 32'(rd_log[0]), 32'h16);
    check("t1_error", 32'(error), 32'd0);
    read_chan("t1_ch6", 6, 12'hABC, 1'b1);

    // channels 0 and 15, slower responder, Start re-pulsed mid-frame
    data_tbl[0]  = 16'h1230;
    data_tbl[15] = 16'hFED7;
    rdy_lat = 3; eoc_lat = 4;
    start_frame(16'h8001);
    wait_done(300, 5, 16'h8001, lat);
    finish_frame(16'h8001);
    check("t2_rd_addr0", 32'(rd_log[0]), 32'h10);
    check("t2_rd_addr1", 32'(rd_log[1]), 32'h1F);
    check("t2_sc_pulses", 32'(sc_cnt), 32'd2);
    check("t2_error", 32'(error), 32'd0);
    read_chan("t2_ch15", 15, 12'hFED, 1'b1);

    // empty mask
    rdy_lat = 1; eoc_lat = 1;
    start_frame(16'h0000);
    wait_done(10, 0, 16'h0000, lat);
    check("t3_done_latency", 32'(lat), 32'd1);
    finish_frame(16'h0000);
    check("t3_den_count", 32'(en_cnt), 32'd0);
    check("t3_sc_count", 32'(sc_cnt), 32'd0);

    // EOC withheld on channel 3 -> timeout
    withhold = 3;
    data_tbl[2] = 16'h5550;
    data_tbl[3] = 16'h7770;
    start_frame(16'h000C);
    wait_done(TO + 300, 0, 16'h000C, lat);
    check("t4_error_sticky", 32'(error), 32'd1);
    check("t4_timeout_window",
          32'((done_cyc - sc_cyc >= TO) && (done_cyc - sc_cyc <= TO + 4)), 32'd1);
    finish_frame(16'h000C);
    read_chan("t4_ch3", 3, 12'h000, 1'b0);
    read_chan("t4_ch2", 2, 12'h555, 1'b1);
    withhold = -1;
    data_tbl[2] = 16'h2220;
    start_frame(16'h0004);
    @(negedge clk);
    check("t4_error_cleared", 32'(error), 32'd0);
    wait_done(100, 0, 16'h0004, lat);
    finish_frame(16'h0004);

    // Start re-pulse, then reset while waiting for read data
    rdy_lat = 4;
    data_tbl[1] = 16'h1110;
    start_frame(16'h0002);
    begin
      int k;
      for (k = 1; k <= 100; k++) begin
        @(negedge clk);
        if (drp_if.Data_En && !drp_if.Data_We) break;
        if (k == 2) begin start = 1'b1; chan_mask = 16'hFFFF; end
        else if (k == 3) begin start = 1'b0; chan_mask = 16'h0002; end
      end
      if (k > 100) begin
        check("t5_read_seen", 32'(drp_if.Data_En), 32'd1);
        end_run();
      end
    end
    @(posedge clk); #1;
    chk_en = 1'b0;
    in_frame = 1'b0;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("t5_busy", 32'(seq_busy), 32'd0);
    check("t5_frame_done", 32'(frame_done), 32'd0);
    check("t5_error", 32'(error), 32'd0);
    check("t5_data_en", 32'(drp_if.Data_En), 32'd0);
    check("t5_data_we", 32'(drp_if.Data_We), 32'd0);
    check("t5_adc_sc", 32'(drp_if.ADC_SC), 32'd0);
    check("t5_addr", 32'(drp_if.ADC_Address), 32'd0);
    check("t5_di", 32'(drp_if.Data_Out), 32'd0);
    for (int i = 0; i < 16; i++) begin
      res_m[i]   = 12'h000;
      valid_m[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk_en = 1'b1;
    sweep_store();
    repeat (10) @(posedge clk);

    // channel 1 twice: raw load, then raw or averaged depending on build
    rdy_lat = 1;
    data_tbl[1] = 16'h4000;
    start_frame(16'h0002);
    wait_done(100, 0, 16'h0002, lat);
    finish_frame(16'h0002);
    read_chan("t6_first", 1, 12'h400, 1'b1);
    data_tbl[1] = 16'h8000;
    start_frame(16'h0002);
    wait_done(100, 0, 16'h0002, lat);
    finish_frame(16'h0002);
`ifdef XSEQ_AVG_EN
    read_chan("t6_second", 1, 12'h500, 1'b1);
`else
    read_chan("t6_second", 1, 12'h800, 1'b1);
`endif

    end_run();
  end

endmodule
